// File: rtl/seq_det_pkg.sv
// Shared types, default sizes and the length-mask helper for the serial pattern detector.
package seq_det_pkg;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned MASK_W    = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Mask of `len` ones in the low bits; callers zero-extend their operands to MASK_W.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        if (len >= MASK_W) begin
            return '1;
        end
        return (MASK_W'(1) << len) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/seq_det_match_core.sv
// History shift register, fill counter and masked pattern compare for the serial detector.
module seq_det_match_core
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match
);

    // The newest bit arrives on `in`, so only PAT_W-1 older bits need storing.
    logic [PAT_W-2:0] history_q, history_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] window;
    logic [LEN_W:0]   fill_next;
    logic             enough;
    logic             equal;

    assign window    = {history_q, in};
    assign fill_next = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    assign enough    = fill_next >= {1'b0, len};
    assign equal     = (MASK_W'(window ^ pattern) & len_mask(32'(len))) == '0;
    assign match     = in_valid & enough & equal;

    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        if (clr) begin
            history_d = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            history_d = window[PAT_W-2:0];
            if (fill_q != LEN_W'(PAT_W)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Config handshake, run/done sequencing and match counting for the programmable detector.
// SEQ_DET_MATCH_REG_EN: when defined, `match` is registered one cycle after the completing bit.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    output logic             cfg_err,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] tgt_q;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             err_q;

    logic cfg_ok;
    logic cfg_take;
    logic clr;
    logic run;
    logic core_match;
    logic hit;
    logic reach;

    assign cfg_ok    = (cfg_len != '0) && (32'(cfg_len) <= PAT_W);
    // abort wins over a config offered in LOADED; in IDLE there is nothing to abort.
    assign cfg_take  = cfg_valid && ((state_q == IDLE) || ((state_q == LOADED) && !abort));
    assign clr       = (state_q == LOADED) && start && !abort;
    assign run       = state_q == RUN;
    assign hit       = core_match && !abort;
    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    assign reach     = hit && (tgt_q != '0) && (count_inc == tgt_q);

    seq_det_match_core #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .in_valid(run && in_valid),
        .in      (in),
        .pattern (pat_q),
        .len     (len_q),
        .match   (core_match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ok) state_d = LOADED;
            end
            LOADED: begin
                if (abort)      state_d = IDLE;
                else if (start) state_d = RUN;
            end
            RUN: begin
                if (abort)      state_d = IDLE;
                else if (reach) state_d = DONE;
            end
            DONE:    state_d = LOADED;
            default: state_d = IDLE;
        endcase
    end

`ifdef SEQ_DET_MATCH_REG_EN
    logic match_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
        end
    end
`endif

    always_comb begin
        cfg_ready   = (state_q == IDLE) || (state_q == LOADED);
        busy        = state_q == RUN;
        done        = state_q == DONE;
        cfg_err     = err_q;
        match_count = count_q;
`ifdef SEQ_DET_MATCH_REG_EN
        match       = match_q;
`else
        match       = hit;
`endif
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (hit) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q   <= cfg_take && !cfg_ok;
            count_q <= count_d;
            if (cfg_take && cfg_ok) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                tgt_q <= cfg_target;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a bit-queue reference model.
module tb_seq_det_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_err;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             din;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;

    seq_det_ctrl #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_target (cfg_target),
        .cfg_err    (cfg_err),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in         (din),
        .match      (match),
        .match_count(match_count),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 configured, 2 running, 3 finished.
    int         m_state;
    logic [7:0] m_pat;
    int         m_len;
    int         m_tgt;
    int         m_count;
    bit         m_err;
    bit         hist[$];
`ifdef SEQ_DET_MATCH_REG_EN
    bit         m_hit_q;
`endif

    logic             s_match, s_err, s_ready, s_busy, s_done;
    logic [CNT_W-1:0] s_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input bit iv, input bit ab, input bit b);
        bit bi;
        if (m_state != 2 || !iv || ab) return 1'b0;
        if (hist.size() + 1 < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            bi = (i == 0) ? b : hist[hist.size() - i];
            if (bi != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pat   = 8'h00;
        m_len   = 0;
        m_tgt   = 0;
        m_count = 0;
        m_err   = 1'b0;
        hist.delete();
`ifdef SEQ_DET_MATCH_REG_EN
        m_hit_q = 1'b0;
`endif
    endtask

    task automatic check_all(input bit hit);
        bit em;
`ifdef SEQ_DET_MATCH_REG_EN
        em = m_hit_q;
`else
        em = hit;
`endif
        chk("cfg_ready", 32'(cfg_ready), 32'(m_state == 0 || m_state == 1));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("match", 32'(match), 32'(em));
        chk("match_count", 32'(match_count), 32'(m_count));
        chk("busy", 32'(busy), 32'(m_state == 2));
        chk("done", 32'(done), 32'(m_state == 3));
    endtask

    task automatic model_update(input bit cv, input logic [7:0] pat, input int len,
                                input logic [7:0] tgt, input bit st, input bit ab,
                                input bit iv, input bit b, input bit hit);
        bit err_n;
        bit ok;
        err_n = 1'b0;
        ok    = (len >= 1) && (len <= PAT_W);
`ifdef SEQ_DET_MATCH_REG_EN
        m_hit_q = hit;
`endif
        case (m_state)
            0: begin
                if (cv) begin
                    if (ok) begin
                        m_pat = pat; m_len = len; m_tgt = int'(tgt); m_state = 1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            1: begin
                if (ab) begin
                    m_state = 0;
                end else begin
                    if (cv) begin
                        if (ok) begin
                            m_pat = pat; m_len = len; m_tgt = int'(tgt);
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    if (st) begin
                        hist.delete();
                        m_count = 0;
                        m_state = 2;
                    end
                end
            end
            2: begin
                if (ab) begin
                    m_state = 0;
                end else if (iv) begin
                    hist.push_back(b);
                    if (hist.size() > PAT_W) void'(hist.pop_front());
                    if (hit) begin
                        if (m_count < 255) m_count++;
                        if (m_tgt != 0 && m_count == m_tgt) m_state = 3;
                    end
                end
            end
            default: m_state = 1;
        endcase
        m_err = err_n;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit cv, input logic [7:0] pat, input logic [3:0] len,
                        input logic [7:0] tgt, input bit st, input bit ab,
                        input bit iv, input bit b);
        bit hit;
        cfg_valid   = cv;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_target  = tgt;
        start       = st;
        abort       = ab;
        in_valid    = iv;
        din         = b;
        @(negedge clk);
        hit = model_hit(iv, ab, b);
        check_all(hit);
        s_match = match;
        s_err   = cfg_err;
        s_ready = cfg_ready;
        s_busy  = busy;
        s_done  = done;
        s_count = match_count;
        model_update(cv, pat, int'(len), tgt, st, ab, iv, b, hit);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input bit pin);
        cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; din = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(1'b0);
        if (pin) begin
            chk("rst_count", 32'(match_count), 32'd0);
            chk("rst_ready", 32'(cfg_ready), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [7:0] mvec;
    logic [8:0] dvec;
    logic [6:0] stream;
    logic [7:0] exp_m1;
    logic [6:0] exp_m4;

    initial begin
        reset = 1'b0;
        cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; din = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b1);

`ifdef SEQ_DET_MATCH_REG_EN
        exp_m1 = 8'h90;
        exp_m4 = 7'h40;
`else
        exp_m1 = 8'h48;
        exp_m4 = 7'h20;
`endif

        // Pattern 1001, free-run: matches on bits 4 and 7.
        stream = 7'b1001001;
        step(1'b1, 8'h09, 4'd4, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        mvec = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, k < 7, (k < 7) ? stream[k] : 1'b0);
            mvec[k] = s_match;
        end
        chk("t1_match_bits", 32'(mvec), 32'(exp_m1));
        chk("t1_count", 32'(s_count), 32'd2);

        // Target 2: done pulses once, then back to LOADED with count held.
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h09, 4'd4, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        dvec = '0;
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, k < 7, (k < 7) ? stream[k] : 1'b0);
            dvec[k] = s_done;
            if (k == 7) chk("t2_busy_in_done", 32'(s_busy), 32'd0);
        end
        chk("t2_done_once", 32'(dvec), 32'h080);
        chk("t2_count_held", 32'(s_count), 32'd2);
        chk("t2_ready_loaded", 32'(s_ready), 32'd1);

        // abort+start in LOADED goes to IDLE; then bad lengths raise cfg_err.
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t3_start_ignored", 32'(s_busy), 32'd0);
        step(1'b1, 8'h09, 4'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t3_err_len0", 32'(s_err), 32'd1);
        chk("t3_ready_len0", 32'(s_ready), 32'd1);
        step(1'b1, 8'h09, 4'd9, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t3_err_len9", 32'(s_err), 32'd1);
        idle();
        chk("t3_err_clears", 32'(s_err), 32'd0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t3_still_idle", 32'(s_busy), 32'd0);

        // Pattern 001, len 3, with gaps: match on the third valid bit only.
        step(1'b1, 8'h01, 4'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        mvec = '0;
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, k[0], k == 5);
            mvec[k] = s_match;
        end
        chk("t4_match_bits", 32'(mvec[6:0]), 32'(exp_m4));
        // A lone 1 right after start must not match against the cleared history.
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h01, 4'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        mvec[0] = s_match;
        idle();
        mvec[1] = s_match;
        chk("t4_no_early_match", 32'(mvec[1:0]), 32'd0);

        // abort on the completing bit suppresses the match and the count.
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h09, 4'd4, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, stream[k]);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        mvec[0] = s_match;
        idle();
        mvec[1] = s_match;
        chk("t5_abort_match", 32'(mvec[1:0]), 32'd0);
        chk("t5_abort_count", 32'(s_count), 32'd0);
        chk("t5_abort_idle", 32'(s_busy), 32'd0);

        // Reset mid-RUN with count 5 loses the configuration.
        step(1'b1, 8'h01, 4'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        chk("t6_count5", 32'(s_count), 32'd5);
        do_reset(1'b1);
        step(1'b0, 8'h00, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t6_start_after_reset", 32'(s_busy), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset(1'b0);
            end else begin
                step($urandom_range(0, 9) == 0,
                     8'($urandom),
                     ($urandom_range(0, 6) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(1, 4)),
                     8'($urandom_range(0, 5)),
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 40) == 0,
                     $urandom_range(0, 3) != 0,
                     1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
